// File: rtl/hex_keypad_entry.sv
// hex_keypad_entry
//   Scans a 4x4 hex keypad (Pmod KYPD) and shifts each debounced keypress into a
//   32-bit value for the seven-segment display path. Newest digit lands in data[3:0].
// Ports
//   clk        system clock, all logic on posedge
//   rst        synchronous active-high reset
//   clr        synchronous clear of data
//   row[3:0]   keypad rows, active-low, asynchronous
//   col[3:0]   keypad column drive, active-low, one-hot-low
//   data[31:0] accumulated digits
//   key_code   most recently accepted key
//   key_valid  1-cycle pulse per accepted key
//   pressed    high while an accepted key is still held
//
// state      | meaning
// IDLE       | no key, waiting for a single-key scan
// PRESS_DB   | candidate key seen, counting stable scans
// HELD       | key accepted, waiting for release
// RELEASE_DB | no key seen, counting stable empty scans
module hex_keypad_entry #(
   parameter int SCAN_CYCLES    = 8192,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic [3:0]  row,
   output logic [3:0]  col,
   output logic [31:0] data,
   output logic [3:0]  key_code,
   output logic        key_valid,
   output logic        pressed
);

   localparam int CW  = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
   localparam int DBW = (DEBOUNCE_SCANS > 0) ? $clog2(DEBOUNCE_SCANS + 1) : 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(SCAN_CYCLES - 1);
   localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_SCANS - 1);

   typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

   state_t         state;
   logic [CW-1:0]  cnt;
   logic [1:0]     col_idx;
   logic [3:0]     row_s1, row_s2;
   logic           acc_one, acc_many;
   logic [3:0]     acc_code;
   logic [3:0]     cand;
   logic [DBW-1:0] db_cnt;

   function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
      case ({r, c})
         4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
         4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
         4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
         4'hC: key_map = 4'h0;  4'hD: key_map = 4'hF;  4'hE: key_map = 4'hE;  default: key_map = 4'hD;
      endcase
   endfunction

   logic [3:0] zeros;
   logic       col_one, col_many;
   logic [1:0] row_idx;
   logic       sample, end_scan;
   logic       sum_one, sum_many;
   logic [3:0] sum_code;
   logic       accept;

   always_comb begin
      zeros    = ~row_s2;
      col_one  = (zeros != 4'h0) && ((zeros & (zeros - 4'd1)) == 4'h0);
      col_many = (zeros != 4'h0) && !col_one;
      row_idx  = 2'd0;
      if (zeros[3]) row_idx = 2'd3;
      if (zeros[2]) row_idx = 2'd2;
      if (zeros[1]) row_idx = 2'd1;
      if (zeros[0]) row_idx = 2'd0;
      // A key in this column plus one from an earlier column also counts as multi-key.
      sum_many = acc_many | col_many | (acc_one & col_one);
      sum_one  = !sum_many && (acc_one || col_one);
      sum_code = col_one ? key_map(row_idx, col_idx) : acc_code;
      sample   = (cnt == CNT_LAST);
      end_scan = sample && (col_idx == 2'd3);
      accept   = end_scan && sum_one &&
                 (((state == IDLE) && (DEBOUNCE_SCANS == 1)) ||
                  ((state == PRESS_DB) && (sum_code == cand) && (db_cnt == DB_LAST)));
   end

   assign col = ~(4'b0001 << col_idx);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         col_idx   <= 2'd0;
         row_s1    <= 4'hF;
         row_s2    <= 4'hF;
         acc_one   <= 1'b0;
         acc_many  <= 1'b0;
         acc_code  <= 4'h0;
         cand      <= 4'h0;
         db_cnt    <= '0;
         data      <= 32'h0;
         key_code  <= 4'h0;
         key_valid <= 1'b0;
         pressed   <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         row_s1    <= row;
         row_s2    <= row_s1;

         if (sample) begin
            cnt     <= '0;
            col_idx <= col_idx + 2'd1;
            if (end_scan) begin
               acc_one  <= 1'b0;
               acc_many <= 1'b0;
               acc_code <= 4'h0;
            end else begin
               acc_one  <= sum_one;
               acc_many <= sum_many;
               acc_code <= sum_code;
            end
         end else begin
            cnt <= cnt + 1'b1;
         end

         if (accept) begin
            key_valid <= 1'b1;
            key_code  <= sum_code;
            data      <= {(clr ? 28'h0 : data[27:0]), sum_code};
         end else if (clr) begin
            data <= 32'h0;
         end

         if (end_scan) begin
            case (state)
               IDLE: begin
                  if (sum_one) begin
                     cand <= sum_code;
                     if (DEBOUNCE_SCANS == 1) begin
                        state   <= HELD;
                        pressed <= 1'b1;
                        db_cnt  <= '0;
                     end else begin
                        state  <= PRESS_DB;
                        db_cnt <= DBW'(1);
                     end
                  end
               end
               PRESS_DB: begin
                  if (sum_one && (sum_code == cand)) begin
                     if (db_cnt == DB_LAST) begin
                        state   <= HELD;
                        pressed <= 1'b1;
                        db_cnt  <= '0;
                     end else begin
                        db_cnt <= db_cnt + 1'b1;
                     end
                  end else begin
                     state  <= IDLE;
                     db_cnt <= '0;
                  end
               end
               HELD: begin
                  if (!sum_one) begin
                     state  <= RELEASE_DB;
                     db_cnt <= DBW'(1);
                  end
               end
               default: begin
                  if (!sum_one) begin
                     if (db_cnt >= DB_LAST) begin
                        state   <= IDLE;
                        pressed <= 1'b0;
                        db_cnt  <= '0;
                     end else begin
                        db_cnt <= db_cnt + 1'b1;
                     end
                  end else begin
                     state  <= HELD;
                     db_cnt <= '0;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_hex_keypad_entry.sv
module tb_hex_keypad_entry;

   logic        clk, rst, clr;
   logic [3:0]  row, col, key_code;
   logic [31:0] data;
   logic        key_valid, pressed;

   logic [15:0] kd;          // kd[r*4+c] = key at row r, column c is down
   int          n_checks = 0;
   int          n_fail   = 0;
   int          pulses   = 0;

   localparam int SCAN = 16; // 4 columns * SCAN_CYCLES

   hex_keypad_entry #(.SCAN_CYCLES(4), .DEBOUNCE_SCANS(2)) dut (
      .clk(clk), .rst(rst), .clr(clr), .row(row), .col(col),
      .data(data), .key_code(key_code), .key_valid(key_valid), .pressed(pressed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Keypad matrix: a row is pulled low only through a pressed key on a driven column.
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!col[c] && kd[r*4+c]) row[r] = 1'b0;
   end

   always @(negedge clk) if (key_valid) pulses++;

   function automatic int key_pos(input logic [3:0] k);
      case (k)
         4'h1: key_pos = 0;  4'h2: key_pos = 1;  4'h3: key_pos = 2;  4'hA: key_pos = 3;
         4'h4: key_pos = 4;  4'h5: key_pos = 5;  4'h6: key_pos = 6;  4'hB: key_pos = 7;
         4'h7: key_pos = 8;  4'h8: key_pos = 9;  4'h9: key_pos = 10; 4'hC: key_pos = 11;
         4'h0: key_pos = 12; 4'hF: key_pos = 13; 4'hE: key_pos = 14; default: key_pos = 15;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic press(input logic [3:0] k);
      kd = 16'h0;
      kd[key_pos(k)] = 1'b1;
   endtask

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Align to the first negedge of a fresh scan (column 0 just driven).
   task automatic sync_scan();
      logic [3:0] p;
      bit ok;
      ok = 0;
      p  = col;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (p == 4'b0111 && col == 4'b1110) begin
            ok = 1;
            break;
         end
         p = col;
      end
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL sync_scan: got no scan start, expected one within 40 cycles");
      end
   endtask

   typedef struct {
      logic [3:0]  key;
      logic [31:0] exp_data;
   } vec_t;
   vec_t vecs[12];

   logic [3:0] exp_col[4];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      vecs[0]  = '{4'h1, 32'h0000_0001};
      vecs[1]  = '{4'h2, 32'h0000_0012};
      vecs[2]  = '{4'hA, 32'h0000_012A};
      vecs[3]  = '{4'h1, 32'h0000_12A1};
      vecs[4]  = '{4'h2, 32'h0001_2A12};
      vecs[5]  = '{4'h3, 32'h0012_A123};
      vecs[6]  = '{4'h4, 32'h012A_1234};
      vecs[7]  = '{4'h5, 32'h12A1_2345};
      vecs[8]  = '{4'h6, 32'h2A12_3456};
      vecs[9]  = '{4'h7, 32'hA123_4567};
      vecs[10] = '{4'h8, 32'h1234_5678};
      vecs[11] = '{4'h9, 32'h2345_6789};
      exp_col[0] = 4'b1110; exp_col[1] = 4'b1101; exp_col[2] = 4'b1011; exp_col[3] = 4'b0111;

      rst = 1'b1; clr = 1'b0; kd = 16'h0;
      wait_neg(3);
      rst = 1'b0;

      // 1. reset values and column stepping
      check("reset_data", data, 32'h0);
      check("reset_key_code", {28'h0, key_code}, 32'h0);
      check("reset_pressed", {31'h0, pressed}, 32'h0);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("col_step_%0d", i), {28'h0, col}, {28'h0, exp_col[i/4]});
         check("reset_key_valid", {31'h0, key_valid}, 32'h0);
         @(negedge clk);
      end

      // 2 + 5. key entry table: hold 6 scans, release 4 scans each
      for (int v = 0; v < 12; v++) begin
         sync_scan();
         p0 = pulses;
         press(vecs[v].key);
         wait_neg(6*SCAN);
         kd = 16'h0;
         wait_neg(4*SCAN);
         #1;
         check($sformatf("vec%0d_pulses", v), pulses - p0, 1);
         check($sformatf("vec%0d_key_code", v), {28'h0, key_code}, {28'h0, vecs[v].key});
         check($sformatf("vec%0d_data", v), data, vecs[v].exp_data);
      end

      // 5. clr coinciding with the accept of 'F'
      sync_scan();
      p0 = pulses;
      press(4'hF);
      wait_neg(31);
      clr = 1'b1;
      wait_neg(1);
      clr = 1'b0;
      #1;
      check("clr_accept_pulse", pulses - p0, 1);
      check("clr_accept_data", data, 32'h0000_000F);
      check("clr_accept_code", {28'h0, key_code}, 32'hF);
      kd = 16'h0;
      wait_neg(4*SCAN);
      @(negedge clk); clr = 1'b1;
      @(negedge clk); clr = 1'b0;
      #1;
      check("clr_only_data", data, 32'h0);
      check("clr_only_code", {28'h0, key_code}, 32'hF);

      // 3. short press, then a key change during debounce
      sync_scan();
      p0 = pulses;
      press(4'h5);
      wait_neg(SCAN);
      kd = 16'h0;
      wait_neg(3*SCAN);
      #1;
      check("short_press_pulses", pulses - p0, 0);
      sync_scan();
      press(4'h5);
      wait_neg(SCAN);
      press(4'h6);
      wait_neg(2*SCAN);
      #1;
      check("switch_no_accept", pulses - p0, 0);
      wait_neg(SCAN);
      #1;
      check("switch_accept", pulses - p0, 1);
      check("switch_code", {28'h0, key_code}, 32'h6);
      check("switch_data", data, 32'h0000_0006);
      kd = 16'h0;
      wait_neg(4*SCAN);

      // 4. two keys at once are rejected; releasing one accepts the other
      sync_scan();
      p0 = pulses;
      kd = 16'h0;
      kd[key_pos(4'h3)] = 1'b1;
      kd[key_pos(4'h7)] = 1'b1;
      wait_neg(4*SCAN);
      #1;
      check("multi_key_pulses", pulses - p0, 0);
      check("multi_key_pressed", {31'h0, pressed}, 32'h0);
      kd[key_pos(4'h7)] = 1'b0;
      wait_neg(2*SCAN);
      #1;
      check("ghost_release_pulse", pulses - p0, 1);
      check("ghost_release_code", {28'h0, key_code}, 32'h3);
      check("ghost_release_pressed", {31'h0, pressed}, 32'h1);
      wait_neg(2*SCAN);
      #1;
      check("ghost_hold_pulses", pulses - p0, 1);
      check("ghost_data", data, 32'h0000_0063);
      kd = 16'h0;
      wait_neg(4*SCAN);
      #1;
      check("release_pressed", {31'h0, pressed}, 32'h0);

      // 6. long hold, then reset while held
      sync_scan();
      p0 = pulses;
      press(4'hD);
      wait_neg(20*SCAN);
      #1;
      check("long_hold_pulses", pulses - p0, 1);
      check("long_hold_pressed", {31'h0, pressed}, 32'h1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_mid_col", {28'h0, col}, {28'h0, 4'b1110});
      check("rst_mid_data", data, 32'h0);
      check("rst_mid_code", {28'h0, key_code}, 32'h0);
      check("rst_mid_valid", {31'h0, key_valid}, 32'h0);
      check("rst_mid_pressed", {31'h0, pressed}, 32'h0);
      p0 = pulses;
      wait_neg(31);
      #1;
      check("reaccept_early", pulses - p0, 0);
      wait_neg(1);
      #1;
      check("reaccept_pulse", pulses - p0, 1);
      check("reaccept_data", data, 32'h0000_000D);
      check("reaccept_pressed", {31'h0, pressed}, 32'h1);
      kd = 16'h0;
      wait_neg(4*SCAN);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
